poly_fios_mm: RTL and testbench
===============================

// Module: poly_fios_mm
// PURPOSE
// - AMNS polynomial Montgomery multiplier using word-level FIOS: R = (A*B + Q*M) mod E / 2^(W*S), E = X^N - LAMBDA.
// - Datapath evaluates one coefficient x WORD_WIDTH-word product per cycle (DSP-sized); operands held in registers.
// - Core processing element of the AMNS modular-multiplication accelerator; fed by the operand store, drives the result store.
// PARAMETERS
// - WORD_WIDTH  17  DSP word width W
// - N           5   coefficients per polynomial
// - LAMBDA      2   external reduction constant (X^N = LAMBDA)
// - S           4   W-bit words per coefficient (coefficient width CW = S*W)
// PORTS
// - clock_i          in   1       single clock, rising edge
// - reset_i          in   1       asynchronous, active-low reset
// - PE_start_i       in   1       level start request
// - A_din_i          in   N*CW    polynomial A, signed coeffs, coeff k at [k*CW +: CW]
// - B_din_i          in   N*CW    polynomial B, same layout
// - M_din_i          in   N*CW    reduction polynomial M, same layout
// - M_prime_0_din_i  in   N*W     low word of M' = -M^-1 mod (E, 2^W), unsigned, coeff k at [k*W +: W]
// - R_dout_o         out  N*CW    result polynomial, signed coeffs
// - busy_o           out  1       high while a multiplication is in progress
// - done_o           out  1       one-cycle pulse, R_dout_o valid
// BEHAVIOUR
// - Reset (reset_i=0, async): state IDLE; busy_o=0, done_o=0, R_dout_o=0, accumulators cleared.
// - IDLE: PE_start_i=1 at a clock edge -> A, B, M, M'0 registered; T=0; j=0; busy_o=1.
// - Per word j=0..S-1 of B (B_j unsigned for j<S-1, signed for j=S-1):
//   MUL_AB (N*N cycles): T += A*B_j mod E; term i+k>=N goes to (i+k-N) times LAMBDA.
//   MUL_Q (N*N cycles): q = (T mod 2^W per coeff)*M'0 mod (E, 2^W); q coeffs unsigned W-bit.
//   MUL_QM (N*N cycles): T += q*M mod E.
//   SHIFT (1 cycle): T = T >>> W (arithmetic, per coeff); j++.
// - After j=S-1: DONE (1 cycle): R_dout_o = low CW bits of each T coeff; done_o=1; busy_o=0 next cycle.
// - Latency start-edge to done_o: S*(3*N*N+1)+1 cycles (305 for defaults).
// - R_dout_o holds until the next DONE. Operand inputs ignored while busy.
// - PE_start_i still high in the cycle after DONE -> next operation starts immediately (back-to-back).
// - Accumulator width: CW+W+clog2(N)+clog2(LAMBDA)+2 bits signed. No saturation. Truncate on output.
// - With valid M, M'0, low W bits of every T coeff are zero before each SHIFT.
// CONFIGURATION
// - Macro POLY_FIOS_OVF_CHECK_EN:
//   Defined: extra port ovf_o (out, 1), registered at DONE. High if any final T coeff does not fit signed CW bits.
//     Cleared by reset.
//   Undefined: port absent, no check logic.
// STRUCTURE
// - Package poly_fios_pkg: state enum {IDLE, MUL_AB, MUL_Q, MUL_QM, SHIFT, DONE};
//   width functions/localparams (CW, ACC_W, latency).
// - Sub-module poly_fios_mac: signed CW x W multiply with LAMBDA-scaled accumulate into one T coeff;
//   one instance, time-multiplexed.
// TESTING (W=17, N=5, S=4, LAMBDA=2)
// - Reset: hold reset_i=0 -> busy_o=0, done_o=0, R_dout_o=0; release -> stays IDLE while PE_start_i=0.
// - Plain product: M=0, M'0=0, A coeff0=655360, B coeff0=2^51, others 0, start
//   -> done_o exactly 305 cycles later; R coeff0=5, others 0.
// - Wrap: M=0, A coeff4=2^17, B coeff1=2^51 -> R coeff0=2 (LAMBDA), others 0.
// - Montgomery: random A, B; valid AMNS M/M'0 -> R*2^68 == A*B mod (E, M-lattice) vs reference model.
//   Assertion: low W bits zero at each SHIFT.
// - Back-to-back: PE_start_i held high -> done_o pulses every 306 cycles; busy_o low only on the DONE->start boundary edge.
// - Reset mid-op: reset_i=0 at cycle 100 -> busy_o=0 immediately, no done_o;
//   restart yields correct result at 305 cycles.

Source files
------------

// File: rtl/poly_fios_pkg.sv
// Shared widths, state encoding and helpers for the AMNS word-level FIOS Montgomery multiplier.
package poly_fios_pkg;

   localparam int WORD_WIDTH = 17;
   localparam int N          = 5;
   localparam int LAMBDA     = 2;
   localparam int S          = 4;

   localparam int W       = WORD_WIDTH;
   localparam int CW      = S * W;
   localparam int ACC_W   = CW + W + $clog2(N) + $clog2(LAMBDA) + 2;
   localparam int IDX_W   = $clog2(N);
   localparam int J_W     = (S > 1) ? $clog2(S) : 1;
   localparam int LATENCY = S * (3 * N * N + 1) + 1;

   typedef enum logic [2:0] {IDLE, MUL_AB, MUL_Q, MUL_QM, SHIFT, DONE} state_e;

   // True when an accumulator value survives truncation to a signed CW-bit coefficient.
   function automatic logic fits_cw(input logic signed [ACC_W-1:0] v);
      return v[ACC_W-1:CW-1] == {(ACC_W-CW+1){v[CW-1]}};
   endfunction

endpackage

// File: rtl/poly_fios_mac.sv
// Signed CW x (W+1) multiply, optionally scaled by LAMBDA for X^N wrap-around, added to one accumulator.
module poly_fios_mac
   import poly_fios_pkg::*;
(
   input  logic signed [CW-1:0]    a_i,
   input  logic signed [W:0]       b_i,
   input  logic                    wrap_i,
   input  logic signed [ACC_W-1:0] acc_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic signed [CW+W:0]    prod;
   logic signed [ACC_W-1:0] term;

   always_comb begin
      prod = (CW+W+1)'(a_i) * (CW+W+1)'(b_i);
      term = ACC_W'(prod);
      if (wrap_i) term = term * signed'(ACC_W'(LAMBDA));
      acc_o = acc_i + term;
   end

endmodule

// File: rtl/poly_fios_mm.sv
// AMNS polynomial Montgomery multiplier (word-level FIOS), one coefficient x word product per cycle.
// Optional overflow flag port ovf_o is built when POLY_FIOS_OVF_CHECK_EN is defined.
module poly_fios_mm
   import poly_fios_pkg::*;
(
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              PE_start_i,
   input  logic [N*CW-1:0]   A_din_i,
   input  logic [N*CW-1:0]   B_din_i,
   input  logic [N*CW-1:0]   M_din_i,
   input  logic [N*W-1:0]    M_prime_0_din_i,
   output logic [N*CW-1:0]   R_dout_o,
   output logic              busy_o,
   output logic              done_o
`ifdef POLY_FIOS_OVF_CHECK_EN
   ,
   output logic              ovf_o
`endif
);

   state_e                  state_q, state_d;
   logic signed [CW-1:0]    a_q [N], a_d [N];
   logic signed [CW-1:0]    b_q [N], b_d [N];
   logic signed [CW-1:0]    m_q [N], m_d [N];
   logic [W-1:0]            mp_q [N], mp_d [N];
   logic signed [ACC_W-1:0] t_q [N], t_d [N];
   logic [W-1:0]            q_q [N], q_d [N];
   logic [J_W-1:0]          j_q, j_d;
   logic [IDX_W-1:0]        i_q, i_d, k_q, k_d;
   logic [N*CW-1:0]         r_q, r_d;
   logic                    busy_q, busy_d, done_q, done_d;

   logic [IDX_W:0]          dsum;
   logic                    wrap;
   logic [IDX_W-1:0]        dst;
   logic                    last_pair;
   logic [W-1:0]            b_word;
   logic signed [CW-1:0]    mac_a;
   logic signed [W:0]       mac_b;
   logic signed [ACC_W-1:0] mac_acc, mac_sum;

   // Term X^(i+k) lands on X^(i+k-N) scaled by LAMBDA once it passes the modulus degree.
   always_comb begin
      dsum      = {1'b0, i_q} + {1'b0, k_q};
      wrap      = dsum >= (IDX_W+1)'(N);
      dst       = wrap ? IDX_W'(dsum - (IDX_W+1)'(N)) : IDX_W'(dsum);
      last_pair = (i_q == IDX_W'(N-1)) && (k_q == IDX_W'(N-1));
      b_word    = b_q[k_q][int'(j_q)*W +: W];
   end

   // The top word of B carries the coefficient sign; lower words are unsigned.
   always_comb begin
      mac_a   = a_q[i_q];
      mac_b   = {(j_q == J_W'(S-1)) ? b_word[W-1] : 1'b0, b_word};
      mac_acc = t_q[dst];
      case (state_q)
         MUL_Q: begin
            mac_a   = {{(CW-W){1'b0}}, t_q[i_q][W-1:0]};
            mac_b   = {1'b0, mp_q[k_q]};
            mac_acc = {{(ACC_W-W){1'b0}}, q_q[dst]};
         end
         MUL_QM: begin
            mac_a = m_q[i_q];
            mac_b = {1'b0, q_q[k_q]};
         end
         default: ;
      endcase
   end

   poly_fios_mac u_mac (
      .a_i    (mac_a),
      .b_i    (mac_b),
      .wrap_i (wrap),
      .acc_i  (mac_acc),
      .acc_o  (mac_sum)
   );

   always_comb begin
      // NOTE: every _d starts from its _q (done from 0) so no branch can leave a latch behind.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      mp_d    = mp_q;
      t_d     = t_q;
      q_d     = q_q;
      j_d     = j_q;
      i_d     = i_q;
      k_d     = k_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (PE_start_i) begin
               for (int n = 0; n < N; n++) begin
                  a_d[n]  = A_din_i[n*CW +: CW];
                  b_d[n]  = B_din_i[n*CW +: CW];
                  m_d[n]  = M_din_i[n*CW +: CW];
                  mp_d[n] = M_prime_0_din_i[n*W +: W];
                  t_d[n]  = '0;
                  q_d[n]  = '0;
               end
               j_d     = '0;
               i_d     = '0;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = MUL_AB;
            end
         end
         MUL_AB, MUL_Q, MUL_QM: begin
            if (state_q == MUL_Q) q_d[dst] = mac_sum[W-1:0];
            else                  t_d[dst] = mac_sum;
            if (k_q == IDX_W'(N-1)) begin
               k_d = '0;
               i_d = i_q + IDX_W'(1);
            end else begin
               k_d = k_q + IDX_W'(1);
            end
            if (last_pair) begin
               i_d     = '0;
               state_d = (state_q == MUL_AB) ? MUL_Q : (state_q == MUL_Q) ? MUL_QM : SHIFT;
            end
         end
         SHIFT: begin
            for (int n = 0; n < N; n++) begin
               t_d[n] = t_q[n] >>> W;
               q_d[n] = '0;
            end
            if (j_q == J_W'(S-1)) begin
               state_d = DONE;
            end else begin
               j_d     = j_q + J_W'(1);
               state_d = MUL_AB;
            end
         end
         DONE: begin
            for (int n = 0; n < N; n++) r_d[n*CW +: CW] = t_q[n][CW-1:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the operand and accumulator arrays are reset as well, so T and R never start undefined.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         for (int n = 0; n < N; n++) begin
            a_q[n]  <= '0;
            b_q[n]  <= '0;
            m_q[n]  <= '0;
            mp_q[n] <= '0;
            t_q[n]  <= '0;
            q_q[n]  <= '0;
         end
         j_q    <= '0;
         i_q    <= '0;
         k_q    <= '0;
         r_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         mp_q    <= mp_d;
         t_q     <= t_d;
         q_q     <= q_d;
         j_q     <= j_d;
         i_q     <= i_d;
         k_q     <= k_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign R_dout_o = r_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;

`ifdef POLY_FIOS_OVF_CHECK_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == DONE) begin
         ovf_d = 1'b0;
         for (int n = 0; n < N; n++) if (!fits_cw(t_q[n])) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_poly_fios_mm.sv
// Scoreboard bench for poly_fios_mm: constant vectors, random Montgomery operands, back-to-back and mid-op reset.
module tb_poly_fios_mm;
   import poly_fios_pkg::*;

   typedef logic [N*CW-1:0] poly_t;
   typedef logic [N*W-1:0]  word_poly_t;
   typedef struct {
      poly_t r;
      int    start;
   } exp_t;

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic       PE_start_i;
   poly_t      A, B, M, R;
   word_poly_t MP;
   logic       busy_o, done_o;
`ifdef POLY_FIOS_OVF_CHECK_EN
   logic       ovf_o;
`endif

   exp_t       sb[$];
   exp_t       mon_e;
   logic [W-1:0] low_or;
   int         cyc;
   int         vectors;
   int         miscompares;

   poly_fios_mm dut (
      .clock_i         (clock_i),
      .reset_i         (reset_i),
      .PE_start_i      (PE_start_i),
      .A_din_i         (A),
      .B_din_i         (B),
      .M_din_i         (M),
      .M_prime_0_din_i (MP),
      .R_dout_o        (R),
      .busy_o          (busy_o),
      .done_o          (done_o)
`ifdef POLY_FIOS_OVF_CHECK_EN
      ,
      .ovf_o           (ovf_o)
`endif
   );

   always #5 clock_i = ~clock_i;
   always @(posedge clock_i) cyc <= cyc + 1;

   task automatic check(input string tag, input poly_t got, input poly_t exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Polynomial-level reference of the FIOS recurrence with wide signed arithmetic.
   function automatic poly_t model(input poly_t a, input poly_t b, input poly_t m, input word_poly_t mp);
      logic signed [127:0]  t [N];
      logic [W-1:0]         q [N];
      logic signed [127:0]  av, bv, f;
      logic signed [CW-1:0] cs;
      logic signed [W-1:0]  ws;
      logic [W-1:0]         wd;
      int                   d;
      poly_t                r;
      for (int n = 0; n < N; n++) t[n] = '0;
      for (int j = 0; j < S; j++) begin
         for (int i = 0; i < N; i++) for (int k = 0; k < N; k++) begin
            d = i + k; f = 1;
            if (d >= N) begin d -= N; f = LAMBDA; end
            cs = a[i*CW +: CW]; av = cs;
            wd = b[k*CW + j*W +: W];
            if (j == S-1) begin ws = wd; bv = ws; end
            else bv = {{(128-W){1'b0}}, wd};
            t[d] = t[d] + f * av * bv;
         end
         for (int n = 0; n < N; n++) q[n] = '0;
         for (int i = 0; i < N; i++) for (int k = 0; k < N; k++) begin
            d = i + k; f = 1;
            if (d >= N) begin d -= N; f = LAMBDA; end
            q[d] = q[d] + W'(f) * t[i][W-1:0] * mp[k*W +: W];
         end
         for (int i = 0; i < N; i++) for (int k = 0; k < N; k++) begin
            d = i + k; f = 1;
            if (d >= N) begin d -= N; f = LAMBDA; end
            cs = m[k*CW +: CW]; av = cs;
            bv = {{(128-W){1'b0}}, q[i]};
            t[d] = t[d] + f * av * bv;
         end
         for (int n = 0; n < N; n++) t[n] = t[n] >>> W;
      end
      r = '0;
      for (int n = 0; n < N; n++) r[n*CW +: CW] = t[n][CW-1:0];
      return r;
   endfunction

   // Valid pair: M'0 = c (constant), M = -c^-1 + 2^W * random, so M*M'0 = -1 mod (E, 2^W).
   task automatic gen_mont(output poly_t a, output poly_t b, output poly_t m, output word_poly_t mp);
      logic [W-1:0]         c, inv;
      longint               x;
      logic signed [CW-1:0] coef;
      c   = W'($urandom()) | W'(1);
      inv = c;
      repeat (4) inv = inv * (W'(2) - c * inv);
      a = '0; b = '0; m = '0; mp = '0;
      mp[W-1:0] = c;
      for (int n = 0; n < N; n++) begin
         x = {$urandom(), $urandom()};
         x = x >>> 5;
         a[n*CW +: CW] = CW'(x);
         b[n*CW +: CW] = CW'({$urandom(), $urandom(), $urandom()});
         x = {$urandom(), $urandom()};
         x = x >>> 23;
         coef = CW'(x);
         coef = coef <<< W;
         if (n == 0) coef = coef - CW'(inv);
         m[n*CW +: CW] = coef;
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_o !== 1'b1 && n < budget) begin
         @(negedge clock_i);
         n++;
      end
      if (done_o !== 1'b1) check("done_timeout", 0, 1);
   endtask

   task automatic run_op(input poly_t a, input poly_t b, input poly_t m, input word_poly_t mp, input poly_t exp);
      exp_t e;
      @(negedge clock_i);
      A = a; B = b; M = m; MP = mp;
      PE_start_i = 1'b1;
      e.r = exp; e.start = cyc + 1;
      sb.push_back(e);
      @(negedge clock_i);
      PE_start_i = 1'b0;
      A = ~a; B = ~b; M = ~m; MP = ~mp;
      check("busy_on", busy_o, 1);
      wait_done(LATENCY + 20);
      check("busy_at_done", busy_o, 0);
      repeat (3) @(negedge clock_i);
      check("r_hold", R, exp);
   endtask

   task automatic run_b2b();
      poly_t      a [3], b [3], m [3], ex [3];
      word_poly_t mp [3];
      exp_t       e;
      for (int i = 0; i < 3; i++) begin
         gen_mont(a[i], b[i], m[i], mp[i]);
         ex[i] = model(a[i], b[i], m[i], mp[i]);
      end
      @(negedge clock_i);
      A = a[0]; B = b[0]; M = m[0]; MP = mp[0];
      PE_start_i = 1'b1;
      e.r = ex[0]; e.start = cyc + 1;
      sb.push_back(e);
      for (int i = 1; i < 3; i++) begin
         @(negedge clock_i);
         check("b2b_busy", busy_o, 1);
         wait_done(LATENCY + 20);
         check("b2b_gap", busy_o, 0);
         A = a[i]; B = b[i]; M = m[i]; MP = mp[i];
         e.r = ex[i]; e.start = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clock_i);
      check("b2b_busy", busy_o, 1);
      wait_done(LATENCY + 20);
      PE_start_i = 1'b0;
      check("b2b_gap", busy_o, 0);
      @(negedge clock_i);
      check("b2b_idle", busy_o, 0);
   endtask

   always @(negedge clock_i) begin
      if (done_o === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("r_dout", R, mon_e.r);
            check("latency", cyc - mon_e.start, LATENCY);
`ifdef POLY_FIOS_OVF_CHECK_EN
            check("ovf", ovf_o, 0);
`endif
         end
      end
      if (reset_i === 1'b1 && dut.state_q == SHIFT) begin
         low_or = '0;
         for (int n = 0; n < N; n++) low_or = low_or | dut.t_q[n][W-1:0];
         check("shift_low_zero", low_or, 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      poly_t      a, b, m, ex;
      word_poly_t mp;
      int         s;

      reset_i = 1'b0; PE_start_i = 1'b0;
      A = '0; B = '0; M = '0; MP = '0;
      repeat (3) @(negedge clock_i);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_r", R, 0);
      reset_i = 1'b1;
      repeat (5) @(negedge clock_i);
      check("idle_busy", busy_o, 0);
      check("idle_done", done_o, 0);

      a = '0; b = '0; m = '0; mp = '0; ex = '0;
      a[CW-1:0] = CW'(655360);
      b[51] = 1'b1;
      ex[CW-1:0] = CW'(5);
      run_op(a, b, m, mp, ex);

      a = '0; b = '0; ex = '0;
      a[4*CW + W] = 1'b1;
      b[1*CW + 51] = 1'b1;
      ex[CW-1:0] = CW'(LAMBDA);
      run_op(a, b, m, mp, ex);

      for (int t = 0; t < 3; t++) begin
         gen_mont(a, b, m, mp);
         run_op(a, b, m, mp, model(a, b, m, mp));
      end

      run_b2b();

      gen_mont(a, b, m, mp);
      ex = model(a, b, m, mp);
      @(negedge clock_i);
      A = a; B = b; M = m; MP = mp;
      PE_start_i = 1'b1;
      s = cyc + 1;
      sb.push_back('{r: ex, start: s});
      @(negedge clock_i);
      PE_start_i = 1'b0;
      while (cyc < s + 100) @(negedge clock_i);
      #2 reset_i = 1'b0;
      #1;
      check("midrst_busy", busy_o, 0);
      check("midrst_done", done_o, 0);
      check("midrst_r", R, 0);
      sb.delete();
      repeat (3) @(negedge clock_i);
      reset_i = 1'b1;
      repeat (250) @(negedge clock_i);
      check("midrst_idle", busy_o, 0);
      run_op(a, b, m, mp, ex);

      repeat (3) @(negedge clock_i);
      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
